pc_sequencer: RTL and testbench

- Registered next-address sequencer for the RISC control path, replacing the purely combinational MUX C path.
- Holds the program counter and selects the next PC using the same branch-select encoding as MUX C: PC+1, conditional BrA, register RAA, or unconditional BrA.
- Adds address-width parametrisation, stall, and subroutine call/return through a parametrised return-address stack with full/empty status and a sticky error flag.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/ras_stack.sv | 63 ++++++
 rtl/pc_sequencer.sv | 95 +++++++++
 tb/tb_pc_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared constants and helpers for the next-address sequencer.
//   BS_* : branch-select encodings {BS1,BS0}, identical to the MUX C path.
//   ptr_width(depth) : bits needed for a stack pointer counting 0..depth.
package pc_seq_pkg;

  localparam logic [1:0] BS_SEQ  = 2'b00;  // PC+1
  localparam logic [1:0] BS_COND = 2'b01;  // BrA if (ps ^ z), else PC+1
  localparam logic [1:0] BS_REG  = 2'b10;  // register jump RAA
  localparam logic [1:0] BS_JMP  = 2'b11;  // unconditional BrA

  // The pointer must represent "depth" itself (full), hence depth+1 values.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/address bundle of the PC sequencer.
//   master : drives en, bs, ps, z, bra, raa, call, ret; observes pc/status.
//   slave  : the sequencer; receives the controls, drives pc, pc_next,
//            stack_empty, stack_full, stack_err.
// There is no valid/ready handshake: every control is sampled on each rising
// clk edge while en=1, and ignored entirely while en=0.
interface pc_sequencer_if #(
  parameter int AW = 10
);
  logic          en;
  logic [1:0]    bs;
  logic          ps;
  logic          z;
  logic [AW-1:0] bra;
  logic [AW-1:0] raa;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic          stack_empty;
  logic          stack_full;
  logic          stack_err;

  modport master (
    output en, bs, ps, z, bra, raa, call, ret,
    input  pc, pc_next, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  en, bs, ps, z, bra, raa, call, ret,
    output pc, pc_next, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: LIFO return-address stack.
//   clk, rst_n : clock, async active-low reset (clears pointer only)
//   push, din  : write din at index sp, sp++ (ignored when full)
//   pop        : sp-- (ignored when empty)
//   top        : entry at sp-1 (don't-care when empty)
//   empty/full : sp==0 / sp==DEPTH, decoded from the registered pointer
// push and pop are never asserted together; the parent resolves that case.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int SPW = ptr_width(DEPTH);

  logic [AW-1:0]  r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic           w_do_push;
  logic           w_do_pop;

  assign empty     = (r_sp == '0);
  assign full      = (r_sp == SPW'(DEPTH));
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  // Contents need no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_sp == SPW'(i)) r_mem[i] <= din;
      end
    end
  end

  // Decoded read avoids indexing with a pointer wider than the array index.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sp == SPW'(i + 1)) top = r_mem[i];
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-address sequencer with subroutine support.
//   clk, rst_n : rising-edge clock, async active-low reset
//   bus (slave): en/bs/ps/z/bra/raa/call/ret in; pc, pc_next (combinational
//                next PC, equal to pc while stalled), stack_empty,
//                stack_full, stack_err (sticky until reset) out.
// Selection priority: call&&ret conflict > call > ret > branch select.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int            AW           = 10,
  parameter int            DEPTH        = 4,
  parameter logic [AW-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_sequencer_if.slave      bus
);

  logic [AW-1:0] r_pc;
  logic          r_err;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_sel;
  logic          w_push;
  logic          w_pop;
  logic          w_err_set;
  logic [AW-1:0] w_top;
  logic          w_empty;
  logic          w_full;

  assign w_inc = r_pc + AW'(1);  // natural wrap at 2^AW

  always_comb begin
    w_sel     = w_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (bus.call && bus.ret) begin
      w_err_set = 1'b1;
    end else if (bus.call) begin
      if (!w_full) begin
        w_push = 1'b1;
        w_sel  = bus.bra;
      end else begin
        w_err_set = 1'b1;
      end
    end else if (bus.ret) begin
      if (!w_empty) begin
        w_pop = 1'b1;
        w_sel = w_top;
      end else begin
        w_err_set = 1'b1;
      end
    end else begin
      case (bus.bs)
        BS_SEQ:  w_sel = w_inc;
        BS_COND: w_sel = (bus.ps ^ bus.z) ? bus.bra : w_inc;
        BS_REG:  w_sel = bus.raa;
        BS_JMP:  w_sel = bus.bra;
        default: w_sel = w_inc;  // unknown select falls back to sequential
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_VECTOR;
      r_err <= 1'b0;
    end else if (bus.en) begin
      r_pc <= w_sel;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  // Stack only moves on an enabled edge, so a stall freezes it as well.
  ras_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.en && w_push),
    .pop   (bus.en && w_pop),
    .din   (w_inc),
    .top   (w_top),
    .empty (w_empty),
    .full  (w_full)
  );

  assign bus.pc          = r_pc;
  assign bus.pc_next     = bus.en ? w_sel : r_pc;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.stack_err   = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam int W     = AW + 3;  // {err, full, empty, pc}

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_sequencer_if #(.AW(AW)) bus ();

  pc_sequencer #(
    .AW           (AW),
    .DEPTH        (DEPTH),
    .RESET_VECTOR ('0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard / model ----------------
  logic [W-1:0]  exp_q [$];
  logic [AW-1:0] m_stk [$];
  logic [AW-1:0] m_pc;
  logic          m_err;
  int            n_checks;
  int            n_fail;

  task automatic model_reset();
    m_pc  = '0;
    m_err = 1'b0;
    m_stk.delete();
    exp_q.delete();
  endtask

  // Drive one cycle from a negedge: predict, push expectation, clock, pop
  // and compare after the edge, then return on the following negedge.
  task automatic step(input logic e, input logic [1:0] b, input logic p,
                      input logic zz, input logic [AW-1:0] ba,
                      input logic [AW-1:0] ra, input logic c, input logic r);
    logic [AW-1:0] inc;
    logic [AW-1:0] nxt;
    logic [W-1:0]  exp_v;
    logic [W-1:0]  got;
    bus.en = e; bus.bs = b; bus.ps = p; bus.z = zz;
    bus.bra = ba; bus.raa = ra; bus.call = c; bus.ret = r;
    #1;
    inc = m_pc + 1'b1;
    nxt = m_pc;
    if (e) begin
      nxt = inc;
      if (c && r) m_err = 1'b1;
      else if (c) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(inc);
          nxt = ba;
        end else m_err = 1'b1;
      end else if (r) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else m_err = 1'b1;
      end else if (b == 2'b01) nxt = (p ^ zz) ? ba : inc;
      else if (b == 2'b10) nxt = ra;
      else if (b == 2'b11) nxt = ba;
    end
    n_checks++;
    if (bus.pc_next !== nxt) begin
      n_fail++;
      $display("FAIL pc_next got=%h exp=%h", bus.pc_next, nxt);
    end
    m_pc = nxt;
    exp_q.push_back({m_err, (m_stk.size() == DEPTH), (m_stk.size() == 0), m_pc});
    @(posedge clk);
    #1;
    got   = {bus.stack_err, bus.stack_full, bus.stack_empty, bus.pc};
    exp_v = exp_q.pop_front();
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL state {err,full,empty,pc} got=%h exp=%h", got, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) step(1, 2'b00, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic jmp(input logic [AW-1:0] a);
    step(1, 2'b11, 0, 0, a, '0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.en = 0; bus.bs = 0; bus.ps = 0; bus.z = 0;
    bus.bra = '0; bus.raa = '0; bus.call = 0; bus.ret = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 0; bus.bs = 0; bus.ps = 0; bus.z = 0;
    bus.bra = '0; bus.raa = '0; bus.call = 0; bus.ret = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.stack_err, bus.stack_full, bus.stack_empty, bus.pc} !== {3'b001, 10'h000}) begin
      n_fail++;
      $display("FAIL reset_state got err=%b full=%b empty=%b pc=%h exp 0/0/1/000",
               bus.stack_err, bus.stack_full, bus.stack_empty, bus.pc);
    end
    rst_n = 1'b1;
    model_reset();
    seq(3);
    n_checks++;
    if (bus.pc !== 10'h003) begin n_fail++; $display("FAIL seq_pc got=%h exp=003", bus.pc); end
    step(0, 2'b11, 0, 0, 10'h155, '0, 1, 0);
    step(0, 2'b10, 0, 0, '0, 10'h0AA, 0, 1);
    n_checks++;
    if (bus.pc !== 10'h003 || bus.pc_next !== 10'h003) begin
      n_fail++;
      $display("FAIL stall_hold got pc=%h pc_next=%h exp=003", bus.pc, bus.pc_next);
    end
  endtask

  task automatic test_cond_branch();
    seq(2);
    n_checks++;
    if (bus.pc !== 10'h005) begin n_fail++; $display("FAIL cond_start got=%h exp=005", bus.pc); end
    step(1, 2'b01, 0, 1, 10'h120, '0, 0, 0);
    n_checks++;
    if (bus.pc !== 10'h120) begin n_fail++; $display("FAIL cond_taken got=%h exp=120", bus.pc); end
    step(1, 2'b01, 1, 1, 10'h120, '0, 0, 0);
    n_checks++;
    if (bus.pc !== 10'h121) begin n_fail++; $display("FAIL cond_not_taken got=%h exp=121", bus.pc); end
    step(1, 2'b10, 0, 0, 10'h120, 10'h2AA, 0, 0);
    n_checks++;
    if (bus.pc !== 10'h2AA) begin n_fail++; $display("FAIL reg_jump got=%h exp=2AA", bus.pc); end
    jmp(10'h120);
    n_checks++;
    if (bus.pc !== 10'h120) begin n_fail++; $display("FAIL uncond_jump got=%h exp=120", bus.pc); end
  endtask

  task automatic test_wrap();
    jmp(10'h3FF);
    seq(1);
    n_checks++;
    if (bus.pc !== 10'h000 || bus.stack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap got pc=%h err=%b exp 000/0", bus.pc, bus.stack_err);
    end
  endtask

  task automatic test_call_ret();
    jmp(10'h010);
    step(1, 2'b00, 0, 0, 10'h200, '0, 1, 0);
    n_checks++;
    if (bus.pc !== 10'h200 || bus.stack_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL call got pc=%h empty=%b exp 200/0", bus.pc, bus.stack_empty);
    end
    seq(2);
    step(1, 2'b00, 0, 0, '0, '0, 0, 1);
    n_checks++;
    if (bus.pc !== 10'h011 || bus.stack_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL ret got pc=%h empty=%b exp 011/1", bus.pc, bus.stack_empty);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [AW-1:0] tgt [4];
    logic [AW-1:0] rpc [4];
    tgt[0] = 10'h100; tgt[1] = 10'h200; tgt[2] = 10'h300; tgt[3] = 10'h040;
    rpc[0] = 10'h301; rpc[1] = 10'h201; rpc[2] = 10'h101; rpc[3] = 10'h001;
    jmp(10'h000);
    for (int i = 0; i < 4; i++) step(1, 2'b00, 0, 0, tgt[i], '0, 1, 0);
    n_checks++;
    if (bus.stack_full !== 1'b1 || bus.pc !== 10'h040) begin
      n_fail++;
      $display("FAIL fill got full=%b pc=%h exp 1/040", bus.stack_full, bus.pc);
    end
    step(1, 2'b00, 0, 0, 10'h155, '0, 1, 0);
    n_checks++;
    if (bus.pc !== 10'h041 || bus.stack_err !== 1'b1 || bus.stack_full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow got pc=%h err=%b full=%b exp 041/1/1",
               bus.pc, bus.stack_err, bus.stack_full);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b00, 0, 0, '0, '0, 0, 1);
      n_checks++;
      if (bus.pc !== rpc[i]) begin
        n_fail++;
        $display("FAIL ret_order[%0d] got=%h exp=%h", i, bus.pc, rpc[i]);
      end
    end
    step(1, 2'b00, 0, 0, '0, '0, 0, 1);
    n_checks++;
    if (bus.pc !== 10'h002 || bus.stack_empty !== 1'b1 || bus.stack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow got pc=%h empty=%b err=%b exp 002/1/1",
               bus.pc, bus.stack_empty, bus.stack_err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      step(logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
           AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)),
           logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0));
    end
  endtask

  task automatic test_conflict_async_reset();
    do_reset();
    jmp(10'h020);
    step(1, 2'b11, 0, 0, 10'h1F0, '0, 1, 1);
    n_checks++;
    if (bus.pc !== 10'h021 || bus.stack_err !== 1'b1 || bus.stack_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict got pc=%h err=%b empty=%b exp 021/1/1",
               bus.pc, bus.stack_err, bus.stack_empty);
    end
    step(1, 2'b00, 0, 0, 10'h100, '0, 1, 0);
    step(1, 2'b00, 0, 0, 10'h200, '0, 1, 0);
    bus.en = 1; bus.bs = 2'b00; bus.call = 0; bus.ret = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.stack_err, bus.stack_full, bus.stack_empty, bus.pc} !== {3'b001, 10'h000}) begin
      n_fail++;
      $display("FAIL async_reset got err=%b full=%b empty=%b pc=%h exp 0/0/1/000",
               bus.stack_err, bus.stack_full, bus.stack_empty, bus.pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seq(2);
  endtask

  // ---------------- main ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_cond_branch();
    test_wrap();
    test_call_ret();
    test_overflow_underflow();
    test_random();
    test_conflict_async_reset();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
